ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Parametrised execute-stage multiply/divide unit. It sits beside the ALU in EX and takes the same forwarded operands as the ALU, selected by the same forwarding selects. It runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, into architectural HI/LO registers. It serves MFHI/MFLO/MTHI/MTLO and asserts a stall to the hazard unit while a result is pending.

## Interface
- NB_REG, 32, operand/HI/LO width (even, ≥8)
- NB_MDOP, 4, width of the multiply/divide opcode
- NB_CNT, $clog2(NB_REG), iteration counter width
- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  reset; one clock, reset asynchronous active-low
- i_valid  in  1  instruction present in EX
- i_flush  in  1  EX instruction is squashed this cycle
- i_md_op  in  NB_MDOP  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, others = NONE
- i_rs_data, i_rt_data  in  NB_REG  register-file operands
- i_result_MEM, i_result_WB  in  NB_REG  forwarded results
- i_forwardA, i_forwardB  in  2  00 reg, 01 WB, 10 MEM, 11 zero
- o_md_result  out  NB_REG  HI (MFHI) or LO (MFLO), else 0
- o_stall  out  1  hold IF/ID/EX this cycle
- o_busy  out  1  iterative operation in flight

## Operation
- Operands A/B come from the 4:1 forwarding muxes; the same muxes feed the start latch and MTHI/MTLO.
- States: IDLE, BUSY, FIX.
- Accept condition: IDLE & i_valid & !i_flush & op∈{MULT,MULTU,DIV,DIVU}.
  - On accept: latch |A|,|B| (magnitudes for signed ops, raw values otherwise), the result signs, and the op kind.
  - Counter loads NB_REG-1 and the state moves to BUSY.
  - Divisor==0 on accept: go straight to FIX with LO={NB_REG{1}}, HI=A (raw), for both signed and unsigned.
- BUSY, multiply: shift-add on a 2·NB_REG accumulator, one multiplier bit per cycle.
- BUSY, divide: restoring divide, one quotient bit per cycle.
- BUSY exits to FIX when the counter reaches 0. Counter decrements by exactly 1 per BUSY cycle; no wrap.
- FIX: apply two's-complement sign correction, then write HI/LO at the end of the cycle and return to IDLE.
  - MULT: {HI,LO} = product, negated if sign(A)^sign(B).
  - DIV: LO = quotient, negated if sign(A)^sign(B); HI = remainder, carrying sign(A).
- MTHI/MTLO: write HI or LO at the clock edge when IDLE & i_valid & !i_flush.
- MFHI/MFLO in IDLE: o_md_result combinationally reflects the current HI/LO.
- o_stall = i_valid & !i_flush & (state≠IDLE) & op≠NONE. Non-MD instructions never stall.
- i_flush never aborts an in-flight operation; that operation belongs to an older, committed instruction. Flush only blocks a new accept or MT write.

## Timing
- Reset (async, any state, including mid-BUSY):
  - state IDLE, HI=LO=0, counter 0, operand latches 0.
  - o_stall=0, o_busy=0, o_md_result=0.
- Latency: accept at edge 0; BUSY for NB_REG cycles; FIX for 1 cycle. HI/LO are valid after edge NB_REG+1 (33 for NB_REG=32).
- Divide-by-zero latency: HI/LO are valid after edge 1.
- o_busy is high in BUSY and FIX. It is low in the accept cycle itself; that instruction does not stall.
- Dependent MF*/MT*/MD op during FIX: stalled in FIX, proceeds the next cycle and sees the new HI/LO.
- MTHI issued while BUSY: stalled; never overwritten by the pending result.
- A new MD op right after FIX is accepted with no bubble.

## Structure
- Shared package/header holds:
  - MD opcode localparams and forwarding-select encodings; the forwarding encodings are shared with the ALU forwarding path.
  - IDLE/BUSY/FIX state encoding.
- Sub-module md_iter_core: accumulator/remainder registers, counter, and per-cycle shift-add/subtract step. Outputs raw magnitude results plus a done flag.
- The top level holds the forwarding muxes, FSM, sign logic, HI/LO registers and stall logic.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7 → stall-free accept; after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → HI=7, LO=0xFFFFFFFF after 2 edges, o_busy high exactly 1 cycle.
- MULTU 6×5, then MFLO next cycle → o_stall high 33 cycles; on release o_md_result=30. An unrelated ALU op in the same slot → o_stall=0.
- i_forwardA=10 (MEM=5), i_forwardB=01 (WB=6), MULTU → LO=30. forwardB=11 → LO=0.
- i_flush on MULT accept cycle → stays IDLE, HI/LO unchanged.
- i_rst_n low mid-BUSY → all outputs 0 immediately; next MULT completes correctly.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// The forwarding selects match the ones the ALU forwarding path uses.
package ex_muldiv_unit_pkg;

  localparam int MD_NONE  = 0;
  localparam int MD_MULT  = 1;
  localparam int MD_MULTU = 2;
  localparam int MD_DIV   = 3;
  localparam int MD_DIVU  = 4;
  localparam int MD_MFHI  = 5;
  localparam int MD_MFLO  = 6;
  localparam int MD_MTHI  = 7;
  localparam int MD_MTLO  = 8;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_md_iter_core.sv
// Iterative magnitude datapath: one shift-add multiply step or one restoring
// divide step per cycle. The accumulator holds {remainder/high, quotient/low}.
module ex_muldiv_unit_md_iter_core #(
  parameter int NB_REG = 32,
  parameter int NB_CNT = $clog2(NB_REG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_div_mode,
  input  logic [NB_REG-1:0] i_a_mag,
  input  logic [NB_REG-1:0] i_b_mag,
  output logic [NB_REG-1:0] o_hi_raw,
  output logic [NB_REG-1:0] o_lo_raw,
  output logic              o_done
);

  logic [2*NB_REG-1:0] acc_q, acc_d;
  logic [NB_REG-1:0]   opb_q, opb_d;
  logic                div_q, div_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;

  logic [NB_REG:0]     add_sum;
  logic [NB_REG:0]     rem_shift;
  logic [NB_REG:0]     rem_diff;
  logic                rem_ge;
  logic [NB_REG-1:0]   rem_next;

  // The shifted partial remainder is always below 2*divisor, so after the
  // trial subtraction (or without it) it fits back into NB_REG bits.
  assign add_sum   = {1'b0, acc_q[2*NB_REG-1:NB_REG]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign rem_shift = acc_q[2*NB_REG-1:NB_REG-1];
  assign rem_diff  = rem_shift - {1'b0, opb_q};
  assign rem_ge    = (rem_shift >= {1'b0, opb_q});
  assign rem_next  = rem_ge ? rem_diff[NB_REG-1:0] : rem_shift[NB_REG-1:0];

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (i_start) begin
      acc_d = {{NB_REG{1'b0}}, i_a_mag};
      opb_d = i_b_mag;
      div_d = i_div_mode;
      cnt_d = NB_CNT'(NB_REG - 1);
    end else if (i_step) begin
      if (div_q) begin
        acc_d = {rem_next, acc_q[NB_REG-2:0], rem_ge};
      end else begin
        acc_d = {add_sum, acc_q[NB_REG-1:1]};
      end
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_hi_raw = acc_q[2*NB_REG-1:NB_REG];
  assign o_lo_raw = acc_q[NB_REG-1:0];
  assign o_done   = i_step && (cnt_q == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: forwarding muxes, IDLE/BUSY/FIX control,
// sign correction, architectural HI/LO and the hazard stall.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_MDOP = 4,
  parameter int NB_CNT  = $clog2(NB_REG)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic [NB_MDOP-1:0] i_md_op,
  input  logic [NB_REG-1:0]  i_rs_data,
  input  logic [NB_REG-1:0]  i_rt_data,
  input  logic [NB_REG-1:0]  i_result_MEM,
  input  logic [NB_REG-1:0]  i_result_WB,
  input  logic [1:0]         i_forwardA,
  input  logic [1:0]         i_forwardB,
  output logic [NB_REG-1:0]  o_md_result,
  output logic               o_stall,
  output logic               o_busy
);

  md_state_e         state_q, state_d;
  logic [NB_REG-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [NB_REG-1:0] araw_q, araw_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_q, div_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;

  logic [NB_REG-1:0] opa, opb, a_mag, b_mag;
  logic              op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo;
  logic              op_arith, op_signed, op_is_div, op_md;
  logic              accept, mt_ok, core_start, core_step, core_done;
  logic [NB_REG-1:0] hi_raw, lo_raw;
  logic [2*NB_REG-1:0] prod_raw, prod_fix;

  always_comb begin
    case (i_forwardA)
      FWD_REG: opa = i_rs_data;
      FWD_WB:  opa = i_result_WB;
      FWD_MEM: opa = i_result_MEM;
      default: opa = '0;
    endcase
    case (i_forwardB)
      FWD_REG: opb = i_rt_data;
      FWD_WB:  opb = i_result_WB;
      FWD_MEM: opb = i_result_MEM;
      default: opb = '0;
    endcase
  end

  assign op_mult   = (i_md_op == NB_MDOP'(MD_MULT));
  assign op_multu  = (i_md_op == NB_MDOP'(MD_MULTU));
  assign op_div    = (i_md_op == NB_MDOP'(MD_DIV));
  assign op_divu   = (i_md_op == NB_MDOP'(MD_DIVU));
  assign op_mfhi   = (i_md_op == NB_MDOP'(MD_MFHI));
  assign op_mflo   = (i_md_op == NB_MDOP'(MD_MFLO));
  assign op_mthi   = (i_md_op == NB_MDOP'(MD_MTHI));
  assign op_mtlo   = (i_md_op == NB_MDOP'(MD_MTLO));
  assign op_arith  = op_mult | op_multu | op_div | op_divu;
  assign op_signed = op_mult | op_div;
  assign op_is_div = op_div | op_divu;
  assign op_md     = op_arith | op_mfhi | op_mflo | op_mthi | op_mtlo;

  assign a_mag  = (op_signed && opa[NB_REG-1]) ? -opa : opa;
  assign b_mag  = (op_signed && opb[NB_REG-1]) ? -opb : opb;
  assign accept = (state_q == ST_IDLE) && i_valid && !i_flush && op_arith;
  assign mt_ok  = (state_q == ST_IDLE) && i_valid && !i_flush;

  assign prod_raw = {hi_raw, lo_raw};
  assign prod_fix = neg_res_q ? -prod_raw : prod_raw;

  // Divide by zero skips the iterations; FIX then writes the fixed pattern.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    araw_d     = araw_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_d      = div_q;
    dz_d       = dz_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          core_start = 1'b1;
          araw_d     = opa;
          neg_res_d  = op_signed & (opa[NB_REG-1] ^ opb[NB_REG-1]);
          neg_rem_d  = op_signed & opa[NB_REG-1];
          div_d      = op_is_div;
          dz_d       = op_is_div && (opb == '0);
          state_d    = (op_is_div && (opb == '0)) ? ST_FIX : ST_BUSY;
        end else if (mt_ok && op_mthi) begin
          hi_d = opa;
        end else if (mt_ok && op_mtlo) begin
          lo_d = opa;
        end
      end
      ST_BUSY: begin
        if (core_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (dz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else if (div_q) begin
          lo_d = neg_res_q ? -lo_raw : lo_raw;
          hi_d = neg_rem_q ? -hi_raw : hi_raw;
        end else begin
          hi_d = prod_fix[2*NB_REG-1:NB_REG];
          lo_d = prod_fix[NB_REG-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      araw_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      araw_q    <= araw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div_q     <= div_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
    end
  end

  assign core_step = (state_q == ST_BUSY);

  ex_muldiv_unit_md_iter_core #(
    .NB_REG (NB_REG),
    .NB_CNT (NB_CNT)
  ) u_md_iter_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (core_start),
    .i_step     (core_step),
    .i_div_mode (op_is_div),
    .i_a_mag    (a_mag),
    .i_b_mag    (b_mag),
    .o_hi_raw   (hi_raw),
    .o_lo_raw   (lo_raw),
    .o_done     (core_done)
  );

  assign o_stall     = i_valid && !i_flush && (state_q != ST_IDLE) && op_md;
  assign o_busy      = busy_q;
  assign o_md_result = op_mfhi ? hi_q : (op_mflo ? lo_q : '0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, multi-cycle
// hazard sequences, and random MULT/DIV traffic against a 64-bit arithmetic model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int NB_REG  = 32;
  localparam int NB_MDOP = 4;
  localparam int LAT     = NB_REG + 1;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_flush = 1'b0;
  logic [3:0]        i_md_op = '0;
  logic [31:0]       i_rs_data = '0, i_rt_data = '0;
  logic [31:0]       i_result_MEM = '0, i_result_WB = '0;
  logic [1:0]        i_forwardA = FWD_REG, i_forwardB = FWD_REG;
  logic [31:0]       o_md_result;
  logic              o_stall, o_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  vec_t vecs[11];

  ex_muldiv_unit #(
    .NB_REG  (NB_REG),
    .NB_MDOP (NB_MDOP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_flush      (i_flush),
    .i_md_op      (i_md_op),
    .i_rs_data    (i_rs_data),
    .i_rt_data    (i_rt_data),
    .i_result_MEM (i_result_MEM),
    .i_result_WB  (i_result_WB),
    .i_forwardA   (i_forwardA),
    .i_forwardB   (i_forwardB),
    .o_md_result  (o_md_result),
    .o_stall      (o_stall),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Architectural result of one MD instruction, straight from the arithmetic.
  function automatic void ref_model(input int op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = '0;
    lo = '0;
    p  = '0;
    case (op)
      MD_MULT: begin
        p = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      MD_DIV: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          hi = sr[31:0];
          lo = sq[31:0];
        end
      end
      MD_DIVU: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic f, input int op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] fwa, input logic [1:0] fwb);
    i_valid    = v;
    i_flush    = f;
    i_md_op    = 4'(op);
    i_rs_data  = a;
    i_rt_data  = b;
    i_forwardA = fwa;
    i_forwardB = fwb;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, MD_NONE, '0, '0, FWD_REG, FWD_REG);
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      tick();
    end
    checkOutput({name, " busy cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    applyStimulus(1'b1, 1'b0, MD_MFHI, '0, '0, FWD_REG, FWD_REG);
    checkOutput({name, " HI"}, 64'(o_md_result), 64'(exp_hi));
    applyStimulus(1'b1, 1'b0, MD_MFLO, '0, '0, FWD_REG, FWD_REG);
    checkOutput({name, " LO"}, 64'(o_md_result), 64'(exp_lo));
    idle();
  endtask

  task automatic runOp(input string name, input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] fwa, input logic [1:0] fwb,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy);
    applyStimulus(1'b1, 1'b0, op, a, b, fwa, fwb);
    checkOutput({name, " accept stall"}, 64'(o_stall), 64'(0));
    tick();
    idle();
    wait_idle(name, exp_busy);
    read_hilo(name, exp_hi, exp_lo);
  endtask

  initial begin
    int n;
    int op;
    logic [31:0] a, b, ehi, elo;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, LAT};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, LAT};
    vecs[3]  = '{MD_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1};
    vecs[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1};
    vecs[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       LAT};
    vecs[6]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, LAT};
    vecs[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, LAT};
    vecs[8]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, LAT};
    vecs[9]  = '{MD_MULTU, 32'd6,        32'd5,        32'd0,        32'd30,       LAT};
    vecs[10] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, LAT};

    // Reset state, with MD traffic presented while held in reset
    #1 i_rst_n = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, MD_MFHI, 32'h11, 32'h22, FWD_REG, FWD_REG);
    checkOutput("reset MFHI", 64'(o_md_result), 64'(0));
    checkOutput("reset busy", 64'(o_busy), 64'(0));
    applyStimulus(1'b1, 1'b0, MD_MULT, 32'h11, 32'h22, FWD_REG, FWD_REG);
    checkOutput("reset stall", 64'(o_stall), 64'(0));
    idle();
    tick();
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, FWD_REG, FWD_REG,
            vecs[i].hi, vecs[i].lo, vecs[i].busy);
    end

    // MFLO right behind MULTU stalls for the whole operation, then sees the product
    applyStimulus(1'b1, 1'b0, MD_MULTU, 32'd6, 32'd5, FWD_REG, FWD_REG);
    tick();
    applyStimulus(1'b1, 1'b0, MD_NONE, 32'd1, 32'd2, FWD_REG, FWD_REG);
    checkOutput("alu op stall", 64'(o_stall), 64'(0));
    applyStimulus(1'b1, 1'b0, 13, 32'd1, 32'd2, FWD_REG, FWD_REG);
    checkOutput("undefined op stall", 64'(o_stall), 64'(0));
    applyStimulus(1'b1, 1'b0, MD_MFLO, '0, '0, FWD_REG, FWD_REG);
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      tick();
    end
    checkOutput("mflo stall cycles", 64'(n), 64'(LAT));
    checkOutput("mflo release", 64'(o_md_result), 64'(30));
    idle();

    // MTHI held behind a busy MULTU lands after the result and is not overwritten
    applyStimulus(1'b1, 1'b0, MD_MULTU, 32'd7, 32'd8, FWD_REG, FWD_REG);
    tick();
    applyStimulus(1'b1, 1'b0, MD_MTHI, 32'h1234, '0, FWD_REG, FWD_REG);
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      tick();
    end
    checkOutput("mthi stall cycles", 64'(n), 64'(LAT));
    tick();
    idle();
    read_hilo("mthi after busy", 32'h1234, 32'd56);

    // A new MD op waiting behind FIX is accepted with no bubble
    applyStimulus(1'b1, 1'b0, MD_MULTU, 32'd3, 32'd4, FWD_REG, FWD_REG);
    tick();
    applyStimulus(1'b1, 1'b0, MD_DIVU, 32'd100, 32'd7, FWD_REG, FWD_REG);
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      tick();
    end
    checkOutput("b2b stall cycles", 64'(n), 64'(LAT));
    tick();
    idle();
    wait_idle("b2b divu", LAT);
    read_hilo("b2b divu", 32'd2, 32'd14);

    // Forwarded operands
    i_result_MEM = 32'd5;
    i_result_WB  = 32'd6;
    runOp("fwd mem*wb", MD_MULTU, 32'hDEAD, 32'hBEEF, FWD_MEM, FWD_WB, 32'd0, 32'd30, LAT);
    runOp("fwd zero", MD_MULTU, 32'hDEAD, 32'hBEEF, FWD_MEM, FWD_ZERO, 32'd0, 32'd0, LAT);
    applyStimulus(1'b1, 1'b0, MD_MTLO, 32'hDEAD, '0, FWD_WB, FWD_REG);
    tick();
    idle();
    read_hilo("mtlo wb", 32'd0, 32'd6);

    // Flush blocks both the accept and MT writes
    runOp("preflush", MD_MULTU, 32'd6, 32'd5, FWD_REG, FWD_REG, 32'd0, 32'd30, LAT);
    applyStimulus(1'b1, 1'b1, MD_MULT, 32'd3, 32'd4, FWD_REG, FWD_REG);
    checkOutput("flush stall", 64'(o_stall), 64'(0));
    tick();
    checkOutput("flush busy", 64'(o_busy), 64'(0));
    applyStimulus(1'b1, 1'b1, MD_MTHI, 32'h5555, '0, FWD_REG, FWD_REG);
    tick();
    idle();
    read_hilo("flush", 32'd0, 32'd30);

    // Asynchronous reset in the middle of BUSY
    applyStimulus(1'b1, 1'b0, MD_MULT, 32'd3, 32'd4, FWD_REG, FWD_REG);
    tick();
    idle();
    repeat (10) tick();
    checkOutput("midbusy busy before reset", 64'(o_busy), 64'(1));
    applyStimulus(1'b1, 1'b0, MD_MFLO, '0, '0, FWD_REG, FWD_REG);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midbusy reset busy", 64'(o_busy), 64'(0));
    checkOutput("midbusy reset stall", 64'(o_stall), 64'(0));
    checkOutput("midbusy reset LO", 64'(o_md_result), 64'(0));
    idle();
    tick();
    i_rst_n = 1'b1;
    tick();
    runOp("after reset", MD_MULT, 32'hFFFFFFFD, 32'd7, FWD_REG, FWD_REG, 32'hFFFFFFFF, 32'hFFFFFFEB, LAT);

    // Random traffic against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(MD_DIVU, MD_MULT));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_model(op, a, b, ehi, elo);
      runOp($sformatf("rand%0d op%0d", i, op), op, a, b, FWD_REG, FWD_REG, ehi, elo,
            ((op == MD_DIV || op == MD_DIVU) && b == 0) ? 1 : LAT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
